// File: rtl/instr_mem_reader_if.sv
// Bundle of the readback engine's control, memory-read and output-stream signals.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready on the output stream; the memory read port is combinational.
//
// Ports (all logic):
//   start, first_addr, last_addr     : dump request and inclusive address range
//   busy, done, cpu_hold             : status and CPU reset request
//   mem_sel, mem_addr, mem_rdata     : memory address-mux takeover and read port
//   out_valid, out_ready, out_data,
//   out_addr, out_last               : instruction word stream
//   checksum                         : running 8-bit sum of transferred words
// Modports: slave = the reader, master = whoever requests dumps and owns the memory/sink.
interface instr_mem_reader_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic [7:0]        checksum;

    modport slave (
        input  start, first_addr, last_addr, mem_rdata, out_ready,
        output busy, done, cpu_hold, mem_sel, mem_addr,
               out_valid, out_data, out_addr, out_last, checksum
    );

    modport master (
        output start, first_addr, last_addr, mem_rdata, out_ready,
        input  busy, done, cpu_hold, mem_sel, mem_addr,
               out_valid, out_data, out_addr, out_last, checksum
    );
endinterface

// File: rtl/instr_mem_reader.sv
// Instruction-memory readback: holds the CPU in reset, walks [first_addr..last_addr] (wrapping), streams words.
// Latency: first out_valid two cycles after the accepted start; 2 cycles per word with out_ready high.
// Backpressure: SEND holds data/address/last stable until out_ready; no words dropped or duplicated.
//
// Ports: prog_clk (clock), prog_reset (synchronous, active-high), bus (instr_mem_reader_if.slave).
module instr_mem_reader #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    instr_mem_reader_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;     // current read address
    logic [ADDR_W:0]   cnt_q, cnt_d;       // words still to transfer, 1..2**ADDR_W
    logic [WIDTH-1:0]  data_q, data_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic              last_q, last_d;
    logic [7:0]        ck_q, ck_d;

    logic [ADDR_W-1:0] span;
    assign span = bus.last_addr - bus.first_addr;   // modular distance handles wrap-around

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oaddr_d = oaddr_q;
        last_d  = last_q;
        ck_d    = ck_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.first_addr;
                    // Extra counter bit lets a full-range dump hold 2**ADDR_W words.
                    cnt_d   = {1'b0, span} + (ADDR_W+1)'(1);
                    ck_d    = 8'd0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                data_d  = bus.mem_rdata;
                oaddr_d = addr_q;
                last_d  = (cnt_q == (ADDR_W+1)'(1));
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    ck_d    = ck_q + 8'(data_q);
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - (ADDR_W+1)'(1);
                    state_d = last_q ? S_DONE : S_SETUP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            oaddr_q <= '0;
            last_q  <= 1'b0;
            ck_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
            last_q  <= last_d;
            ck_q    <= ck_d;
        end
    end

    // Status decoded straight from state so cpu_hold cannot dip between words.
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.cpu_hold  = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mem_sel   = (state_q == S_SETUP) || (state_q == S_SEND);
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = (state_q == S_SEND);
    assign bus.out_data  = data_q;
    assign bus.out_addr  = oaddr_q;
    assign bus.out_last  = last_q;
    assign bus.checksum  = ck_q;
endmodule

// File: tb/tb_instr_mem_reader.sv
// Directed bench for instr_mem_reader: memory holds 3*i, words/timing/checksum checked against hand values.
// Latency: n/a.
// Backpressure: exercised with an out_ready pattern of 0,0,1 per word.
module tb_instr_mem_reader;
    logic prog_clk = 1'b0;
    logic prog_reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 prog_clk = ~prog_clk;

    instr_mem_reader_if #(.WIDTH(8), .ADDR_W(4)) bus ();

    instr_mem_reader #(.WIDTH(8), .ADDR_W(4)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .bus        (bus)
    );

    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'(3 * i);
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     bus.busy,      0);
        check({tag, "_done"},     bus.done,      0);
        check({tag, "_hold"},     bus.cpu_hold,  0);
        check({tag, "_sel"},      bus.mem_sel,   0);
        check({tag, "_valid"},    bus.out_valid, 0);
        check({tag, "_last"},     bus.out_last,  0);
        check({tag, "_mem_addr"}, bus.mem_addr,  0);
        check({tag, "_out_addr"}, bus.out_addr,  0);
        check({tag, "_out_data"}, bus.out_data,  0);
        check({tag, "_checksum"}, bus.checksum,  0);
    endtask

    // mode 0: ready high; mode 1: ready 0,0,1 per word; mode 2: ready high plus a stray start mid-dump.
    // exp_done counts clock edges from the accepting edge to the first sample showing done.
    task automatic do_dump(input logic [3:0] f, input logic [3:0] l, input int mode,
                           input int nw, input int exp_done, input logic [7:0] exp_ck);
        int         k;
        int         words;
        int         h;
        logic [3:0] e;
        bit         fin;
        bus.first_addr = f;
        bus.last_addr  = l;
        bus.start      = 1'b1;
        bus.out_ready  = (mode != 1);
        tick();
        bus.start      = 1'b0;
        bus.first_addr = ~f;
        bus.last_addr  = ~l;
        check("acc_busy",  bus.busy,      1);
        check("acc_hold",  bus.cpu_hold,  1);
        check("acc_sel",   bus.mem_sel,   1);
        check("acc_valid", bus.out_valid, 0);
        check("acc_ck",    bus.checksum,  0);
        k = 0; words = 0; h = 0; e = f; fin = 1'b0;
        while (!fin && k < 400) begin
            tick();
            k++;
            if (mode == 2 && k == 3) begin
                bus.start = 1'b1; bus.first_addr = 4'd10; bus.last_addr = 4'd10;
            end else if (mode == 2 && k == 4) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                check("done_cycle", k, exp_done);
                check("done_words", words, nw);
                check("done_ck",    bus.checksum, exp_ck);
                check("done_hold",  bus.cpu_hold, 1);
                fin = 1'b1;
            end else begin
                check("hold_high", bus.cpu_hold, 1);
                if (bus.out_valid) begin
                    check("word_data", bus.out_data, 8'(3 * e));
                    check("word_addr", bus.out_addr, e);
                    check("word_last", bus.out_last, (words == nw - 1));
                    check("word_sel",  bus.mem_sel,  1);
                    if (mode == 1) begin
                        bus.out_ready = (h == 2);
                        h = (h == 2) ? 0 : h + 1;
                    end
                    if (bus.out_ready) begin
                        words++;
                        e = e + 4'd1;
                    end
                end else if (mode == 1) begin
                    bus.out_ready = 1'b0;
                end
            end
        end
        if (!fin) check("done_timeout", 0, 1);
        tick();
        check("post_busy", bus.busy, 0);
        check("post_done", bus.done, 0);
        check("post_ck",   bus.checksum, exp_ck);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int n;
        bus.start      = 1'b0;
        bus.first_addr = 4'd0;
        bus.last_addr  = 4'd0;
        bus.out_ready  = 1'b1;
        prog_reset     = 1'b1;
        tick();
        tick();
        prog_reset = 1'b0;
        check_all_zero("rst");
        tick();
        check_all_zero("idle");

        // Full range, 16 words, done 32 edges after accept, checksum 360 mod 256.
        do_dump(4'd0, 4'd15, 0, 16, 32, 8'h68);
        // Wrapped range 14,15,0,1.
        do_dump(4'd14, 4'd1, 0, 4, 8, 8'h5A);
        // Single word.
        do_dump(4'd7, 4'd7, 0, 1, 2, 8'h15);
        // Backpressure: 4 cycles per word.
        do_dump(4'd0, 4'd3, 1, 4, 16, 8'h12);
        // Stray start while busy: 2..5 still read, 6+9+12+15.
        do_dump(4'd2, 4'd5, 2, 4, 8, 8'h2A);
        // Full range with start addr 5 wraps to 4: still 16 words, same sum.
        do_dump(4'd5, 4'd4, 0, 16, 32, 8'h68);

        // Reset in SEND of the 6th word (address 5) of a 0..15 dump.
        bus.first_addr = 4'd0;
        bus.last_addr  = 4'd15;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!(bus.out_valid && bus.out_addr == 4'd5) && n < 40) begin
            tick();
            n++;
        end
        check("rst_reach_word5", (bus.out_valid && bus.out_addr == 4'd5), 1);
        check("rst_partial_ck",  bus.checksum, 8'd30);
        prog_reset = 1'b1;
        tick();
        check_all_zero("midrst");
        prog_reset = 1'b0;
        tick();
        check_all_zero("midrst_idle");
        do_dump(4'd0, 4'd15, 0, 16, 32, 8'h68);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_mem_reader.md
# instr_mem_reader

Hardware readback engine for the 4-bit CPU's 16 x 8-bit instruction memory; the read-side counterpart of the program-write path that loads instructions through `prog_we`/`prog_addr`/`prog_data`. On a start request it holds the CPU in reset, takes over the memory address mux, walks a programmed address range, and streams each instruction word out over a valid/ready interface with an address tag, a last flag and a running 8-bit checksum. It verifies a loaded program before the CPU is released.

## Interface
Parameters:
- `WIDTH`, 8: instruction word width; must match the memory `WIDTH`.
- `ADDR_W`, 4: memory address width; depth is 2**ADDR_W.

Ports:
- `prog_clk` in 1: single clock for all state.
- `prog_reset` in 1: reset; synchronous, active-high.
- `start` in 1: begin a dump. Sampled only in IDLE.
- `first_addr` in ADDR_W: first address to read. Captured on the accepted `start`.
- `last_addr` in ADDR_W: last address to read. Captured on the accepted `start`.
- `busy` out 1: high from the cycle after an accepted start through DONE, inclusive.
- `done` out 1: one-cycle pulse in DONE.
- `cpu_hold` out 1: drives the CPU reset request. Equals `busy`.
- `mem_sel` out 1: address-mux select; 1 routes `mem_addr` to the memory. High in SETUP and SEND.
- `mem_addr` out ADDR_W: read address.
- `mem_rdata` in WIDTH: memory read data. The read port is combinational from the address.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accept.
- `out_data` out WIDTH: instruction word.
- `out_addr` out ADDR_W: address of `out_data`.
- `out_last` out 1: high with the final word of the range.
- `checksum` out 8: running sum mod 256 of all transferred words. Holds its value after DONE until the next accepted start.

## Operation
- States and transitions:
  - IDLE → SETUP on `start`.
  - SETUP → SEND after exactly 1 cycle.
  - SEND → SETUP on a transfer that is not the last word.
  - SEND → DONE on the last transfer.
  - DONE → IDLE after 1 cycle.
- A transfer occurs when `out_valid & out_ready` is true at the rising edge.
- On an accepted start:
  - Latch `first_addr`.
  - Compute word count = ((last_addr − first_addr) mod 2**ADDR_W) + 1, range 1..16. Hold it in an ADDR_W+1-bit down-counter.
  - Clear `checksum` to 0.
- SETUP:
  - Drive `mem_addr` = current address and `mem_sel` = 1.
  - At the end of the cycle, register `mem_rdata` into `out_data`, the current address into `out_addr`, and (count == 1) into `out_last`.
- SEND:
  - `out_valid` = 1. `out_data`, `out_addr` and `out_last` are stable until the transfer.
  - `mem_addr` holds the current address.
- On each transfer:
  - `checksum` += `out_data` (mod 256).
  - Address increments mod 2**ADDR_W, so 15 wraps to 0.
  - Counter decrements.
- Wrap-around: `last_addr` < `first_addr` wraps through 15 → 0. `first_addr` == `last_addr` reads exactly one word. A full-range dump (e.g. 0..15, or 5..4) is 16 words.
- `start` while busy is ignored; latched values are unchanged.
- `cpu_hold` stays high continuously from SETUP through DONE, never glitching low between words.
- The block never writes memory. It has no write-enable output.

## Timing
- Reset values: state IDLE; `busy`, `done`, `cpu_hold`, `mem_sel`, `out_valid` and `out_last` = 0; `mem_addr`, `out_addr`, `out_data` and `checksum` = 0.
- `prog_reset` mid-dump: at the next edge all outputs take their reset values and the state returns to IDLE; the partial checksum is discarded.
- A start sampled at edge t gives SETUP in cycle t+1 and the first `out_valid` in cycle t+2.
- With `out_ready` held high, each word costs 2 cycles. An N-word dump has `done` in cycle t+2N+1 and `busy` low in cycle t+2N+2.
- When `out_ready` is low, SEND holds indefinitely with no data or address change.
- `checksum` updates the cycle after each transfer. It is final and stable when `done` = 1.

## Test plan
- Memory[i] = 3·i, range 0..15, `out_ready` = 1 → 16 words with `out_addr` 0..15 and data 0,3,…,45. `out_last` is high only on address 15. `done` at t+33. `checksum` = 0x68. `cpu_hold` is high from t+1 through t+33.
- Same contents, range 14..1 → 4 words at addresses 14, 15, 0, 1 with data 42, 45, 0, 3. `checksum` = 0x5A.
- Range 7..7 → one word, address 7, data 21, `out_last` = 1 on that word, `done` at t+3, `checksum` = 0x15.
- Range 0..3 with `out_ready` toggled 0,0,1 per word → each word is held stable while not ready. There are no duplicate or dropped words. Final `checksum` = 0x12.
- `start` pulsed again mid-dump with a different range → the dump continues on the original range with the original word count.
- `prog_reset` asserted in SEND after the 5th word of a 0..15 dump → next cycle all outputs are 0 and the state is IDLE. A new start then dumps the full range correctly.
